// File: rtl/dual_low_qualifier_pkg.sv
// Shared definitions for the dual-active-low qualifier: FSM state encoding
// and the width of the qualification/release counter.
package dual_low_qualifier_pkg;

    // Width of the qualification/release counter.
    localparam int CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    // Qualifier FSM states. The encoding is fixed so that other blocks in
    // the library can decode it directly.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // condition absent, output low
        QUAL   = 2'd1,  // both inputs low, counting toward assertion
        ACTIVE = 2'd2,  // condition accepted, output high
        REL    = 2'd3   // condition lost, counting toward release
    } qual_state_t;

    // Converts a count parameter into the counter's native width.
    function automatic cnt_t to_cnt(input int value);
        return cnt_t'(value);
    endfunction

    // Reports whether a state drives the qualified level high.
    function automatic logic level_of(input qual_state_t st);
        return (st == ACTIVE) || (st == REL);
    endfunction

endpackage

// File: rtl/dual_low_qualifier_if.sv
// Signal bundle between the asynchronous board-side strobes and the
// qualifier. The master side drives the enable and the two active-low
// inputs. The slave side (the qualifier) returns the level and the pulse.
interface dual_low_qualifier_if;

    logic CE;  // clock enable for the qualifier FSM and counter
    logic I0;  // active-low asynchronous input
    logic I1;  // active-low asynchronous input
    logic O;   // qualified level
    logic P;   // one-cycle pulse on each assertion of O

    modport master (
        output CE,
        output I0,
        output I1,
        input  O,
        input  P
    );

    modport slave (
        input  CE,
        input  I0,
        input  I1,
        output O,
        output P
    );

endinterface

// File: rtl/dual_low_qualifier_sync_ff_chain.sv
// Multi-flop synchroniser for one asynchronous input. CLR presets every
// stage to 1, so an active-low strobe reads as inactive out of reset.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic C,
    input  logic CLR,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the input one stage per clock, preset to inactive on CLR.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            chain <= '1;
        end else begin
            // NOTE: non-blocking assignment makes each stage take its
            // predecessor's value from before the edge, so the chain
            // really delays by STAGES clocks instead of collapsing.
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/dual_low_qualifier.sv
// Registered, glitch-filtered dual-active-low AND. Both inputs are
// synchronised, then a four-state FSM requires ASSERT_CNT consecutive
// enabled cycles of both-low before raising O and DEASSERT_CNT consecutive
// enabled cycles without both-low before dropping it. P marks each rise.
module dual_low_qualifier
    import dual_low_qualifier_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,  // 2..4
    parameter int ASSERT_CNT   = 4,  // 1..255
    parameter int DEASSERT_CNT = 4   // 1..255
) (
    input  logic                  C,
    input  logic                  CLR,
    dual_low_qualifier_if.slave   bus
);

    localparam cnt_t ASSERT_LIM   = to_cnt(ASSERT_CNT);
    localparam cnt_t DEASSERT_LIM = to_cnt(DEASSERT_CNT);

    logic        i0_sync;
    logic        i1_sync;
    logic        s;
    qual_state_t state;
    cnt_t        cnt;
    cnt_t        cnt_inc;
    logic        o_q;
    logic        p_q;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_i0 (
        .C   (C),
        .CLR (CLR),
        .d   (bus.I0),
        .q   (i0_sync)
    );

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_i1 (
        .C   (C),
        .CLR (CLR),
        .d   (bus.I1),
        .q   (i1_sync)
    );

    // Both synchronised inputs low: the raw condition being qualified.
    assign s = ~i0_sync & ~i1_sync;

    // The counter never exceeds the larger limit (at most 255), and every
    // path that reaches a limit reloads it, so this increment cannot wrap.
    assign cnt_inc = cnt + to_cnt(1);

    // Qualifier FSM with registered level and pulse outputs; CE gates
    // every state and counter change, while P always clears when idle.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            cnt   <= '0;
            o_q   <= 1'b0;
            p_q   <= 1'b0;
        end else if (!bus.CE) begin
            // State, count and level hold; the pulse is never stretched.
            p_q <= 1'b0;
        end else begin
            p_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        if (ASSERT_CNT == 1) begin
                            state <= ACTIVE;
                            cnt   <= '0;
                            o_q   <= 1'b1;
                            p_q   <= 1'b1;
                        end else begin
                            state <= QUAL;
                            cnt   <= to_cnt(1);
                        end
                    end
                end

                QUAL: begin
                    if (s) begin
                        if (cnt_inc == ASSERT_LIM) begin
                            state <= ACTIVE;
                            cnt   <= '0;
                            o_q   <= 1'b1;
                            p_q   <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Any break in the low-low run restarts qualification.
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                ACTIVE: begin
                    if (!s) begin
                        if (DEASSERT_CNT == 1) begin
                            state <= IDLE;
                            cnt   <= '0;
                            o_q   <= 1'b0;
                        end else begin
                            state <= REL;
                            cnt   <= to_cnt(1);
                        end
                    end
                end

                REL: begin
                    if (!s) begin
                        if (cnt_inc == DEASSERT_LIM) begin
                            state <= IDLE;
                            cnt   <= '0;
                            o_q   <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Condition came back before release completed:
                        // O never dropped, so this is not a new assertion.
                        state <= ACTIVE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    o_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O = o_q;
    assign bus.P = p_q;

endmodule

// File: tb/tb_dual_low_qualifier.sv
// Self-checking bench for dual_low_qualifier at SYNC/ASSERT/DEASSERT = 2/4/4.
// A run-length model (streak of enabled edges disagreeing with the current
// level) predicts O and P every cycle; directed phases pin literal values.
module tb_dual_low_qualifier;
    import dual_low_qualifier_pkg::*;

    localparam int SYNC_STAGES  = 2;
    localparam int ASSERT_CNT   = 4;
    localparam int DEASSERT_CNT = 4;

    logic C;
    logic CLR;
    int   checks = 0;
    int   errors = 0;

    dual_low_qualifier_if bus ();

    dual_low_qualifier #(
        .SYNC_STAGES  (SYNC_STAGES),
        .ASSERT_CNT   (ASSERT_CNT),
        .DEASSERT_CNT (DEASSERT_CNT)
    ) dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Inputs reach the decision logic SYNC_STAGES edges after being sampled;
    // O flips once the condition has disagreed with it for the required
    // number of consecutive enabled edges.
    bit q0[$];
    bit q1[$];
    bit m_o = 1'b0;
    bit m_p = 1'b0;
    int streak = 0;

    always @(posedge C or posedge CLR) begin
        bit cond;
        if (CLR) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < SYNC_STAGES; i++) begin
                q0.push_back(1'b1);
                q1.push_back(1'b1);
            end
            m_o    = 1'b0;
            m_p    = 1'b0;
            streak = 0;
        end else begin
            cond = !q0[0] && !q1[0];
            m_p  = 1'b0;
            if (bus.CE) begin
                if (cond != m_o) begin
                    streak++;
                    if (streak >= (m_o ? DEASSERT_CNT : ASSERT_CNT)) begin
                        m_p    = !m_o;
                        m_o    = !m_o;
                        streak = 0;
                    end
                end else begin
                    streak = 0;
                end
            end
            q0.push_back(bus.I0);
            q1.push_back(bus.I1);
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge C) begin
        check_bit("model_o", bus.O, m_o);
        check_bit("model_p", bus.P, m_p);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        CLR    = 1'b1;
        bus.CE = 1'b1;
        bus.I0 = 1'b0;
        bus.I1 = 1'b0;

        // Reset held with both inputs low: outputs stay low.
        repeat (3) step();
        check_bit("rst_o", bus.O, 1'b0);
        check_bit("rst_p", bus.P, 1'b0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        CLR = 1'b0;

        // Nominal assertion: O and P rise after edge 6, P clears after edge 7.
        for (int e = 1; e <= 7; e++) begin
            step();
            check_bit("nom_o", bus.O, e >= 6);
            check_bit("nom_p", bus.P, e == 6);
        end

        // One-edge glitch on I0 while active: O holds, no new pulse.
        bus.I0 = 1'b1;
        step();
        bus.I0 = 1'b0;
        for (int e = 0; e < 7; e++) begin
            check_bit("glitch_o", bus.O, 1'b1);
            check_bit("glitch_p", bus.P, 1'b0);
            step();
        end
        check("glitch_state", 32'(dut.state), 32'(ACTIVE));

        // Held release: O falls after the sixth edge sampling I0 high.
        bus.I0 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            check_bit("rel_o", bus.O, n < 6);
            check_bit("rel_p", bus.P, 1'b0);
        end

        // Both-low pulse of three edges: too short to assert.
        bus.I0 = 1'b0;
        repeat (3) step();
        bus.I1 = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            check_bit("short_o", bus.O, 1'b0);
        end
        check("short_state", 32'(dut.state), 32'(IDLE));
        check("short_cnt", 32'(dut.cnt), 32'd0);

        // CE stall at cnt=2 during qualification.
        bus.I1 = 1'b0;
        repeat (4) step();
        check("stall_pre_cnt", 32'(dut.cnt), 32'd2);
        check("stall_pre_state", 32'(dut.state), 32'(QUAL));
        bus.CE = 1'b0;
        for (int e = 0; e < 5; e++) begin
            step();
            check("stall_cnt", 32'(dut.cnt), 32'd2);
            check_bit("stall_o", bus.O, 1'b0);
        end
        bus.CE = 1'b1;
        step();
        check_bit("resume1_o", bus.O, 1'b0);
        check("resume1_cnt", 32'(dut.cnt), 32'd3);
        step();
        check_bit("resume2_o", bus.O, 1'b1);
        check_bit("resume2_p", bus.P, 1'b1);
        step();
        check_bit("resume3_p", bus.P, 1'b0);

        // Asynchronous CLR while active clears O without a clock edge.
        @(negedge C);
        #2;
        CLR = 1'b1;
        #1;
        check_bit("aclr_o", bus.O, 1'b0);
        check_bit("aclr_p", bus.P, 1'b0);
        step();
        CLR = 1'b0;

        // Re-qualification after reset takes the full six edges.
        for (int e = 1; e <= 6; e++) begin
            step();
            check_bit("requal_o", bus.O, e >= 6);
            check_bit("requal_p", bus.P, e == 6);
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
